// File: rtl/n64_vi_tx_pkg.sv
// Shared constants, types and helpers for the N64 video-interface test transmitter.
// Default timing follows a 773 x 263 NTSC field with a 7-bit colour bus.
package n64_vi_tx_pkg;

  localparam int COLOR_W = 7;

  localparam int H_TOTAL_DEF     = 773;
  localparam int H_SYNC_DEF      = 57;
  localparam int H_ACT_START_DEF = 128;
  localparam int H_ACT_END_DEF   = 768;
  localparam int V_TOTAL_DEF     = 263;
  localparam int V_SYNC_DEF      = 3;
  localparam int V_ACT_START_DEF = 20;
  localparam int V_ACT_END_DEF   = 260;

  localparam int CLAMP_W = 16;
  localparam int BAR_W   = 80;

  localparam logic [COLOR_W-1:0] LVL_BLACK = 7'h00;
  localparam logic [COLOR_W-1:0] LVL_GREY  = 7'h40;
  localparam logic [COLOR_W-1:0] LVL_FULL  = 7'h7F;
  localparam logic [COLOR_W-1:0] SYNC_IDLE = 7'h0F;

  typedef enum logic [1:0] {
    PAT_GREY  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } phase_e;

  typedef struct packed {
    logic     blur_en;
    logic     n64_480i;
    pattern_e pattern;
  } cfg_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Bars run white, yellow, ... black: inverted index bits select R/G/B full scale.
  function automatic rgb_t bar_rgb(input logic [2:0] idx);
    logic [2:0] c;
    c = ~idx;
    return '{r: c[2] ? LVL_FULL : LVL_BLACK,
             g: c[1] ? LVL_FULL : LVL_BLACK,
             b: c[0] ? LVL_FULL : LVL_BLACK};
  endfunction

endpackage

// File: rtl/n64_vi_timing.sv
// Nibble phase, pixel/line/field counters and sync decode for the VI transmitter.
// Decoded syncs are combinational; the top level registers them onto the pins.
module n64_vi_timing
  import n64_vi_tx_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int H_W     = $clog2(H_TOTAL),
  parameter int V_W     = $clog2(V_TOTAL + 2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           interlace,
  output logic [1:0]     phase_p0,
  output logic [H_W-1:0] h_p0,
  output logic [V_W-1:0] v_p0,
  output logic [3:0]     sync_p0,
  output logic           frame_start_p0
);

  localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_SYNC_END  = H_W'(H_SYNC);
  localparam logic [H_W-1:0] H_SERR      = H_W'(H_TOTAL - H_SYNC);
  localparam logic [H_W-1:0] H_HALF      = H_W'(H_TOTAL / 2);
  localparam logic [H_W-1:0] H_CLAMP_END = H_W'(H_SYNC + CLAMP_W);
  localparam logic [V_W-1:0] V_LAST_EVEN = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST_ODD  = V_W'(V_TOTAL);
  localparam logic [V_W-1:0] V_SYNC_END  = V_W'(V_SYNC);

  logic           field_p0;
  logic [V_W-1:0] v_last;
  logic           vline, hs_lo, vs_lo, cs_lo, cl_lo;

  assign v_last = field_p0 ? V_LAST_ODD : V_LAST_EVEN;

  // Field parity for the next field is decided with the config of the field now ending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_p0 <= 2'd0;
      h_p0     <= '0;
      v_p0     <= '0;
      field_p0 <= 1'b0;
    end else begin
      phase_p0 <= phase_p0 + 2'd1;
      if (phase_p0 == 2'd3) begin
        if (h_p0 == H_LAST) begin
          h_p0 <= '0;
          if (v_p0 == v_last) begin
            v_p0     <= '0;
            field_p0 <= interlace & ~field_p0;
          end else begin
            v_p0 <= v_p0 + V_W'(1);
          end
        end else begin
          h_p0 <= h_p0 + H_W'(1);
        end
      end
    end
  end

  // Odd fields start vsync half a line late and release it half a line late.
  always_comb begin
    vline = v_p0 < V_SYNC_END;
    hs_lo = h_p0 < H_SYNC_END;
    if (field_p0)
      vs_lo = ((v_p0 == '0) && (h_p0 >= H_HALF)) ||
              ((v_p0 != '0) && vline) ||
              ((v_p0 == V_SYNC_END) && (h_p0 < H_HALF));
    else
      vs_lo = vline;
    cs_lo          = vline ? (h_p0 < H_SERR) : hs_lo;
    cl_lo          = !vline && (h_p0 >= H_SYNC_END) && (h_p0 < H_CLAMP_END);
    sync_p0        = {~vs_lo, ~cl_lo, ~hs_lo, ~cs_lo};
    frame_start_p0 = (phase_p0 == 2'd0) && (h_p0 == '0) && (v_p0 == '0);
  end

endmodule

// File: rtl/n64_vi_tx.sv
// N64 VI bus transmitter: sync/R/G/B nibble multiplexing of generated test patterns
// with optional horizontal two-tap blur; all pins registered one clock after the counters.
module n64_vi_tx
  import n64_vi_tx_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF
) (
  input  logic               nCLK,
  input  logic               DRV_RST,
  input  logic [3:0]         cfg_i,
  output logic               nDSYNC,
  output logic [COLOR_W-1:0] D_o,
  output logic               frame_start_o
);

  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(V_TOTAL + 2);
  localparam logic [H_W-1:0] HA_START = H_W'(H_ACT_START);
  localparam logic [H_W-1:0] HA_END   = H_W'(H_ACT_END);
  localparam logic [V_W-1:0] VA_START = V_W'(V_ACT_START);
  localparam logic [V_W-1:0] VA_END   = V_W'(V_ACT_END);
  localparam logic [6:0]     BAR_LAST = 7'(BAR_W - 1);

  logic [1:0]     phase_p0;
  logic [H_W-1:0] h_p0, hx_p0;
  logic [V_W-1:0] v_p0;
  logic [3:0]     sync_p0;
  logic           frame_start_p0;
  cfg_t           cfg_p0;
  logic           act_p0;
  logic [6:0]     bar_cnt_p0;
  logic [2:0]     bar_idx_p0;
  rgb_t           raw_p0, prev_p0, pix_p0;

  function automatic logic [COLOR_W-1:0] blur_avg(input logic [COLOR_W-1:0] a,
                                                  input logic [COLOR_W-1:0] b);
    logic [COLOR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return COLOR_W'(s >> 1);
  endfunction

  n64_vi_timing #(
    .H_TOTAL (H_TOTAL),
    .H_SYNC  (H_SYNC),
    .V_TOTAL (V_TOTAL),
    .V_SYNC  (V_SYNC),
    .H_W     (H_W),
    .V_W     (V_W)
  ) u_timing (
    .clk            (nCLK),
    .rst            (DRV_RST),
    .interlace      (cfg_p0.n64_480i),
    .phase_p0       (phase_p0),
    .h_p0           (h_p0),
    .v_p0           (v_p0),
    .sync_p0        (sync_p0),
    .frame_start_p0 (frame_start_p0)
  );

  // Config is latched only on the frame-start nibble; bar position is a divide-free pixel count.
  always_ff @(posedge nCLK or posedge DRV_RST) begin
    if (DRV_RST) begin
      cfg_p0     <= '0;
      bar_cnt_p0 <= '0;
      bar_idx_p0 <= '0;
    end else begin
      if (frame_start_p0)
        cfg_p0 <= cfg_t'(cfg_i);
      if (phase_p0 == 2'd3) begin
        if (!act_p0) begin
          bar_cnt_p0 <= '0;
          bar_idx_p0 <= '0;
        end else if (bar_cnt_p0 == BAR_LAST) begin
          bar_cnt_p0 <= '0;
          bar_idx_p0 <= bar_idx_p0 + 3'd1;
        end else begin
          bar_cnt_p0 <= bar_cnt_p0 + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge nCLK) begin
    if (phase_p0 == 2'd3)
      prev_p0 <= raw_p0;
  end

  always_comb begin
    act_p0 = (h_p0 >= HA_START) && (h_p0 < HA_END) && (v_p0 >= VA_START) && (v_p0 < VA_END);
    hx_p0  = h_p0 - HA_START;
    raw_p0 = '0;
    if (act_p0) begin
      case (cfg_p0.pattern)
        PAT_GREY:  raw_p0 = '{r: LVL_GREY, g: LVL_GREY, b: LVL_GREY};
        PAT_BARS:  raw_p0 = bar_rgb(bar_idx_p0);
        PAT_CHECK: raw_p0 = (h_p0[0] ^ v_p0[0]) ? '0 : '{r: LVL_FULL, g: LVL_FULL, b: LVL_FULL};
        PAT_RAMP:  raw_p0 = '{r: COLOR_W'(hx_p0), g: COLOR_W'(hx_p0), b: COLOR_W'(hx_p0)};
        default:   raw_p0 = '0;
      endcase
    end
  end

  always_comb begin
    pix_p0 = raw_p0;
    if (cfg_p0.blur_en && act_p0 && hx_p0[0])
      pix_p0 = '{r: blur_avg(prev_p0.r, raw_p0.r),
                 g: blur_avg(prev_p0.g, raw_p0.g),
                 b: blur_avg(prev_p0.b, raw_p0.b)};
  end

  // ---- pin stage: one nCLK after counter state ----
  always_ff @(posedge nCLK or posedge DRV_RST) begin
    if (DRV_RST) begin
      nDSYNC        <= 1'b1;
      D_o           <= SYNC_IDLE;
      frame_start_o <= 1'b0;
    end else begin
      nDSYNC        <= (phase_p0 != 2'd0);
      frame_start_o <= frame_start_p0;
      case (phase_e'(phase_p0))
        PH_SYNC: D_o <= {3'b000, sync_p0};
        PH_R:    D_o <= pix_p0.r;
        PH_G:    D_o <= pix_p0.g;
        PH_B:    D_o <= pix_p0.b;
        default: D_o <= SYNC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_vi_tx.sv
// Randomised scoreboard bench for n64_vi_tx on a reduced raster geometry.
// The reference computes every nibble from its linear position within the field.
module tb_n64_vi_tx;

  localparam int HT  = 180;
  localparam int HS  = 9;
  localparam int HAS = 20;
  localparam int HAE = 176;
  localparam int VT  = 9;
  localparam int VS  = 2;
  localparam int VAS = 3;
  localparam int VAE = 8;
  localparam int LINE_CYC = 4 * HT;
  localparam int RST_AT   = 4 * LINE_CYC + 4 * 50 + 2;

  logic       nCLK    = 1'b0;
  logic       DRV_RST = 1'b1;
  logic [3:0] cfg_i   = 4'h0;
  logic       nDSYNC;
  logic [6:0] D_o;
  logic       frame_start_o;

  typedef struct {
    logic       nds;
    logic [6:0] d;
    logic       fs;
    int         n;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, errors = 0, fs_seen = 0, fs_pushed = 0;
  int n = 0, flen = 0, fields = 0, junk_at = -1, pidx = 0;
  logic odd = 1'b0, first = 1'b1;
  logic [3:0] mcfg = 4'h0;
  logic [3:0] plan [13] = '{4'h0, 4'h1, 4'h2, 4'hA, 4'h3, 4'hF,
                            4'h9, 4'h4, 4'h6, 4'hE, 4'h4, 4'h0, 4'h0};

  always #5 nCLK = ~nCLK;

  n64_vi_tx #(
    .H_TOTAL (HT), .H_SYNC (HS), .H_ACT_START (HAS), .H_ACT_END (HAE),
    .V_TOTAL (VT), .V_SYNC (VS), .V_ACT_START (VAS), .V_ACT_END (VAE)
  ) dut (
    .nCLK          (nCLK),
    .DRV_RST       (DRV_RST),
    .cfg_i         (cfg_i),
    .nDSYNC        (nDSYNC),
    .D_o           (D_o),
    .frame_start_o (frame_start_o)
  );

  function automatic bit active(int h, int v);
    return h >= HAS && h < HAE && v >= VAS && v < VAE;
  endfunction

  // c: 0 = red, 1 = green, 2 = blue
  function automatic int raw_px(int h, int v, logic [1:0] pat, int c);
    int cb;
    if (!active(h, v)) return 0;
    case (pat)
      2'd0: return 'h40;
      2'd1: begin
        cb = 7 - (((h - HAS) / 80) % 8);
        return ((cb >> (2 - c)) & 1) != 0 ? 'h7F : 0;
      end
      2'd2: return (((h ^ v) & 1) == 0) ? 'h7F : 0;
      default: return (h - HAS) % 128;
    endcase
  endfunction

  function automatic int px(int h, int v, logic [3:0] cfg, int c);
    if (cfg[3] && active(h, v) && ((h - HAS) % 2 == 1))
      return (raw_px(h - 1, v, cfg[1:0], c) + raw_px(h, v, cfg[1:0], c)) / 2;
    return raw_px(h, v, cfg[1:0], c);
  endfunction

  function automatic logic [3:0] sync_nib(int h, int v, logic fodd);
    int pos;
    bit vs, hs, cs, cl, vl;
    pos = v * HT + h;
    vs  = fodd ? (pos >= HT / 2 && pos < VS * HT + HT / 2) : (pos < VS * HT);
    hs  = h < HS;
    vl  = v < VS;
    cs  = vl ? (h < HT - HS) : hs;
    cl  = !vl && h >= HS && h < HS + 16;
    return {!vs, !cl, !hs, !cs};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " nDSYNC"}, int'(nDSYNC), 1);
    check({tag, " D_o"}, int'(D_o), 'h0F);
    check({tag, " frame_start_o"}, int'(frame_start_o), 0);
  endtask

  // Monitor: the nibble expected for counter state k appears on the pins after the next edge.
  always @(posedge nCLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (frame_start_o === 1'b1) fs_seen++;
      if ({nDSYNC, D_o, frame_start_o} !== {mon_e.nds, mon_e.d, mon_e.fs}) begin
        errors++;
        $display("FAIL pins at line %0d pixel %0d phase %0d: got nDSYNC=%b D_o=%h fs=%b, expected nDSYNC=%b D_o=%h fs=%b",
                 (mon_e.n / 4) / HT, (mon_e.n / 4) % HT, mon_e.n % 4,
                 nDSYNC, D_o, frame_start_o, mon_e.nds, mon_e.d, mon_e.fs);
      end
    end
  end

  // Called between edges: advances the reference by one nibble and schedules its expectation.
  task automatic tick();
    exp_t e;
    int ph, pix, h, v;
    if (n == 0) begin
      odd     = first ? 1'b0 : (mcfg[2] ? ~odd : 1'b0);
      first   = 1'b0;
      mcfg    = cfg_i;
      flen    = (VT + (odd ? 1 : 0)) * LINE_CYC;
      fields++;
      junk_at = 4 * LINE_CYC + int'($urandom_range(0, LINE_CYC - 1));
    end
    if (n == junk_at) cfg_i = 4'($urandom);
    if (n == flen - LINE_CYC) begin
      cfg_i = plan[pidx];
      pidx++;
    end
    ph  = n % 4;
    pix = n / 4;
    h   = pix % HT;
    v   = pix / HT;
    e.n = n;
    if (ph == 0) begin
      e.nds = 1'b0;
      e.d   = {3'b000, sync_nib(h, v, odd)};
      e.fs  = (pix == 0);
    end else begin
      e.nds = 1'b1;
      e.d   = 7'(px(h, v, mcfg, ph - 1));
      e.fs  = 1'b0;
    end
    if (e.fs) fs_pushed++;
    exp_q.push_back(e);
    n++;
    if (n == flen) n = 0;
  endtask

  task automatic release_reset();
    @(posedge nCLK);
    #2;
    cfg_i   = plan[pidx];
    pidx++;
    DRV_RST = 1'b0;
    n       = 0;
    first   = 1'b1;
    fields  = 0;
    tick();
  endtask

  initial begin
    repeat (10) @(posedge nCLK);
    #1;
    check_reset("reset_hold");

    release_reset();
    while (!(fields == 6 && n == RST_AT)) begin
      @(posedge nCLK);
      #2;
      tick();
    end

    // Asynchronous reset in the middle of a line
    @(posedge nCLK);
    #2;
    DRV_RST = 1'b1;
    #1;
    check_reset("reset_async");
    repeat (4) @(posedge nCLK);
    #1;
    check_reset("reset_held");

    release_reset();
    while (fields < 7) begin
      @(posedge nCLK);
      #2;
      tick();
    end

    repeat (3) @(posedge nCLK);
    #2;
    check("frame_start_count", fs_seen, fs_pushed);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
